// File: rtl/sum_ctrl_pkg.sv
// Shared key map, FSM state encoding and default sizes for the keypad BCD-add controller.
package sum_ctrl_pkg;

    localparam int unsigned NDIG_DEF = 3;
    localparam int unsigned KW_DEF   = 4;

    localparam logic [3:0] KEY_PLUS = 4'hA;
    localparam logic [3:0] KEY_EQ   = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;

    typedef enum logic [1:0] {
        ENTER_A  = 2'b00,
        ENTER_B  = 2'b01,
        WAIT_SUM = 2'b10,
        SHOW     = 2'b11
    } ctrl_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'h9;
    endfunction

endpackage

// File: rtl/key_event_det.sv
// Synchronizes the raw keypad level and emits one event per press with its captured code.
module key_event_det
    import sum_ctrl_pkg::*;
#(
    parameter int unsigned KW = KW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [KW-1:0] key_code_i,
    input  logic          key_pressed_i,
    output logic          key_evt_o,
    output logic [KW-1:0] key_val_o
);

    logic [1:0]    sync_q;
    logic          lvl_prev_q;
    logic [KW-1:0] code_s1_q;
    logic [KW-1:0] code_s2_q;

    // The code follows the same two-stage path as the level so both line up at the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            lvl_prev_q <= 1'b0;
            code_s1_q  <= '0;
            code_s2_q  <= '0;
        end else begin
            sync_q     <= {sync_q[0], key_pressed_i};
            lvl_prev_q <= sync_q[1];
            code_s1_q  <= key_code_i;
            code_s2_q  <= code_s1_q;
        end
    end

    assign key_evt_o = sync_q[1] & ~lvl_prev_q;
    assign key_val_o = code_s2_q;

endmodule

// File: rtl/sum_entry_ctrl.sv
// Keypad entry FSM: builds BCD operands A and B, runs one add handshake, shows the sum.
//   state    | meaning
//   ENTER_A  | digits shift into operand A
//   ENTER_B  | digits shift into operand B
//   WAIT_SUM | add_req held, waiting for add_ack
//   SHOW     | latched sum on display
module sum_entry_ctrl
    import sum_ctrl_pkg::*;
#(
    parameter int unsigned NDIG = NDIG_DEF,
    parameter int unsigned KW   = KW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KW-1:0]       key_code_i,
    input  logic                key_pressed_i,
    output logic [4*NDIG-1:0]   op_a_o,
    output logic [4*NDIG-1:0]   op_b_o,
    output logic                add_req_o,
    input  logic                add_ack_i,
    input  logic [4*NDIG+3:0]   add_sum_i,
    output logic [4*NDIG+3:0]   disp_val_o,
    output logic [1:0]          phase_o
);

    localparam int unsigned CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(NDIG);

    logic          key_evt;
    logic [KW-1:0] key_val;
    logic [3:0]    key_nib;

    ctrl_state_t         state_q, state_d;
    logic [4*NDIG-1:0]   op_a_q, op_a_d;
    logic [4*NDIG-1:0]   op_b_q, op_b_d;
    logic [CW-1:0]       cnt_a_q, cnt_a_d;
    logic [CW-1:0]       cnt_b_q, cnt_b_d;
    logic [4*NDIG+3:0]   result_q, result_d;
    logic                add_req_q, add_req_d;

    key_event_det #(.KW(KW)) u_key_det (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_code_i    (key_code_i),
        .key_pressed_i (key_pressed_i),
        .key_evt_o     (key_evt),
        .key_val_o     (key_val)
    );

    assign key_nib = key_val[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ENTER_A;
            op_a_q    <= '0;
            op_b_q    <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            result_q  <= '0;
            add_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            result_q  <= result_d;
            add_req_q <= add_req_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        result_d  = result_q;
        add_req_d = add_req_q;

        unique case (state_q)
            ENTER_A: begin
                if (key_evt && is_digit(key_nib)) begin
                    if (cnt_a_q < CNT_MAX) begin
                        op_a_d  = {op_a_q[4*NDIG-5:0], key_nib};
                        cnt_a_d = cnt_a_q + CW'(1);
                    end
                end else if (key_evt && key_nib == KEY_PLUS) begin
                    state_d = ENTER_B;
                    op_b_d  = '0;
                    cnt_b_d = '0;
                end
            end
            ENTER_B: begin
                if (key_evt && is_digit(key_nib)) begin
                    if (cnt_b_q < CNT_MAX) begin
                        op_b_d  = {op_b_q[4*NDIG-5:0], key_nib};
                        cnt_b_d = cnt_b_q + CW'(1);
                    end
                end else if (key_evt && key_nib == KEY_EQ) begin
                    state_d   = WAIT_SUM;
                    add_req_d = 1'b1;
                end
            end
            WAIT_SUM: begin
                if (add_ack_i) begin
                    result_d  = add_sum_i;
                    add_req_d = 1'b0;
                    state_d   = SHOW;
                end
            end
            SHOW: begin
                // A digit here starts a fresh calculation with that digit already entered in A.
                if (key_evt && is_digit(key_nib)) begin
                    op_a_d  = {{(4*NDIG-4){1'b0}}, key_nib};
                    cnt_a_d = CW'(1);
                    op_b_d  = '0;
                    cnt_b_d = '0;
                    state_d = ENTER_A;
                end
            end
            default: state_d = ENTER_A;
        endcase

        if (key_evt && key_nib == KEY_CLR) begin
            state_d   = ENTER_A;
            op_a_d    = '0;
            op_b_d    = '0;
            cnt_a_d   = '0;
            cnt_b_d   = '0;
            result_d  = '0;
            add_req_d = 1'b0;
        end
    end

    always_comb begin
        disp_val_o = {4'h0, op_a_q};
        unique case (state_q)
            ENTER_A:           disp_val_o = {4'h0, op_a_q};
            ENTER_B, WAIT_SUM: disp_val_o = {4'h0, op_b_q};
            SHOW:              disp_val_o = result_q;
            default:           disp_val_o = {4'h0, op_a_q};
        endcase
    end

    assign op_a_o    = op_a_q;
    assign op_b_o    = op_b_q;
    assign add_req_o = add_req_q;
    assign phase_o   = state_q;

endmodule

// File: tb/tb_sum_entry_ctrl.sv
// Directed bench for sum_entry_ctrl: entry, add handshake, clear, reset and key latency.
module tb_sum_entry_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  key_code;
    logic        key_pressed;
    logic [11:0] op_a;
    logic [11:0] op_b;
    logic        add_req;
    logic        add_ack;
    logic [15:0] add_sum;
    logic [15:0] disp_val;
    logic [1:0]  phase;

    int n_checks = 0;
    int n_errors = 0;

    sum_entry_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_code_i    (key_code),
        .key_pressed_i (key_pressed),
        .op_a_o        (op_a),
        .op_b_o        (op_b),
        .add_req_o     (add_req),
        .add_ack_i     (add_ack),
        .add_sum_i     (add_sum),
        .disp_val_o    (disp_val),
        .phase_o       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Key rises between edges (on a falling edge), held 4 cycles, then released.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_code    = code;
        key_pressed = 1'b1;
        idle(4);
        key_pressed = 1'b0;
        idle(4);
    endtask

    task automatic ack(input logic [15:0] sum);
        @(negedge clk);
        add_sum = sum;
        add_ack = 1'b1;
        @(negedge clk);
        add_ack = 1'b0;
        idle(1);
    endtask

    initial begin
        rst_n       = 1'b0;
        key_code    = 4'h0;
        key_pressed = 1'b0;
        add_ack     = 1'b0;
        add_sum     = 16'h0;
        idle(3);
        chk("reset_op_a", op_a, 0);
        chk("reset_disp", disp_val, 0);
        chk("reset_phase", phase, 0);
        chk("reset_req", add_req, 0);
        rst_n = 1'b1;
        idle(2);

        // Held key: single event, lands on the third edge after the rise.
        @(negedge clk);
        key_code    = 4'h7;
        key_pressed = 1'b1;
        @(posedge clk); #1 chk("lat_edge1", op_a, 12'h000);
        @(posedge clk); #1 chk("lat_edge2", op_a, 12'h000);
        @(posedge clk); #1 chk("lat_edge3", op_a, 12'h007);
        idle(50);
        key_pressed = 1'b0;
        idle(4);
        chk("hold_single", op_a, 12'h007);

        press(4'hC);
        chk("clr_a", op_a, 0);
        press(4'h9); press(4'h8); press(4'h7); press(4'h6);
        chk("ovf_op_a", op_a, 12'h987);
        chk("ovf_disp", disp_val, 16'h0987);

        press(4'hC);
        press(4'h1); press(4'h2); press(4'h3);
        chk("t1_op_a", op_a, 12'h123);
        press(4'hA);
        chk("t1_phase_b", phase, 2'b01);
        chk("t1_b_zero", op_b, 0);
        press(4'h4); press(4'h5); press(4'h6);
        chk("t1_op_b", op_b, 12'h456);
        chk("t1_disp_b", disp_val, 16'h0456);
        press(4'hB);
        chk("t1_phase_wait", phase, 2'b10);
        chk("t1_req", add_req, 1);
        press(4'h9);
        idle(10);
        chk("t1_req_held", add_req, 1);
        chk("t1_hold_a", op_a, 12'h123);
        chk("t1_hold_b", op_b, 12'h456);
        ack(16'h0579);
        chk("t1_req_drop", add_req, 0);
        chk("t1_disp_sum", disp_val, 16'h0579);
        chk("t1_phase_show", phase, 2'b11);
        press(4'hB);
        chk("show_eq_ign", phase, 2'b11);

        press(4'h5);
        chk("t6_phase", phase, 2'b00);
        chk("t6_op_a", op_a, 12'h005);
        chk("t6_op_b", op_b, 0);
        press(4'hB); press(4'hD); press(4'hE); press(4'hF);
        chk("t6_ign_a", op_a, 12'h005);
        chk("t6_ign_phase", phase, 2'b00);
        press(4'h2);
        chk("t6_cnt_restart", op_a, 12'h052);

        press(4'hC);
        press(4'h1); press(4'hA); press(4'h2); press(4'hB);
        chk("t4_req", add_req, 1);
        chk("t4_disp", disp_val, 16'h0002);
        press(4'hC);
        chk("t4_req_clr", add_req, 0);
        chk("t4_phase", phase, 2'b00);
        chk("t4_op_b", op_b, 0);
        ack(16'h0003);
        chk("t4_late_phase", phase, 2'b00);
        chk("t4_late_disp", disp_val, 0);
        chk("t4_late_req", add_req, 0);

        press(4'h1); press(4'h2);
        chk("t5_pre", op_a, 12'h012);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_a", op_a, 0);
        chk("t5_async_disp", disp_val, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        press(4'h4); press(4'h3);
        chk("t5_restart", op_a, 12'h043);

        // Empty B: EQUALS straight after PLUS adds zero.
        press(4'hA); press(4'hB);
        chk("emptyb_phase", phase, 2'b10);
        chk("emptyb_op_b", op_b, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
